priority_bit_scanner: RTL and testbench

Parametrised, registered successor to the team's 16-bit combinational priority encoder. It accepts a WIDTH-bit request vector over a valid/ready handshake. In single mode it returns the index of the highest-priority set bit; in enumerate mode it returns every set bit's index, one per beat, in priority order. It sits between a request-collecting register and any consumer that services requests one at a time, such as an arbiter, interrupt dispatcher or display driver.

---
 rtl/priority_bit_scanner_if.sv | 26 ++
 rtl/priority_bit_scanner.sv | 142 ++++++++++++++
 tb/tb_priority_bit_scanner.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_bit_scanner_if.sv
// Request/beat bundle for priority_bit_scanner: request vector in, bit indices out.
// The master side is the upstream producer plus downstream consumer; the scanner is the slave.
interface priority_bit_scanner_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_idx;
    logic             out_last;
    logic             out_zero;

    modport master (
        output in_valid, in_vec, in_mode, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_vec, in_mode, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_zero
    );
endinterface

// File: rtl/priority_bit_scanner.sv
// Registered priority scanner: returns the top-priority set bit of a captured vector,
// or every set bit in priority order (one per beat) in enumerate mode.
//
//   state  | meaning
//   IDLE   | no vector held, in_ready=1
//   EMIT   | presenting a beat from work/mode/zero
module priority_bit_scanner #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned OUT_W     = 8,
    parameter logic [63:0] ZERO_CODE = 64'hF0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    priority_bit_scanner_if.slave bus
);
    localparam logic [OUT_W-1:0] ZCODE = OUT_W'(ZERO_CODE);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_nxt;
    logic [WIDTH-1:0] w_sel;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic [OUT_W-1:0] w_pos;
    logic             w_rest_zero;
    logic             w_last;
    logic             w_load;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [OUT_W-1:0] w_out_idx;
    logic             w_out_last;
    logic             w_out_zero;

    // Last match in scan order wins, so scan upward for MSB priority and downward otherwise.
    always_comb begin
        w_sel = '0;
        w_pos = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (r_work[i]) begin
                    w_sel    = '0;
                    w_sel[i] = 1'b1;
                    w_pos    = OUT_W'(i);
                end
            end
        end else begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (r_work[i]) begin
                    w_sel    = '0;
                    w_sel[i] = 1'b1;
                    w_pos    = OUT_W'(i);
                end
            end
        end
    end

    assign w_rest_zero = ((r_work & ~w_sel) == '0);
    assign w_last      = r_zero | ~r_mode | w_rest_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_work_nxt  = r_work;
        w_mode_nxt  = r_mode;
        w_zero_nxt  = r_zero;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_idx   = '0;
        w_out_last  = 1'b0;
        w_out_zero  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_out_valid = 1'b1;
                w_out_idx   = r_zero ? ZCODE : w_pos;
                w_out_last  = w_last;
                w_out_zero  = r_zero;
                w_in_ready  = bus.out_ready & w_last;
                if (bus.out_ready) begin
                    if (!w_last) begin
                        w_work_nxt = r_work & ~w_sel;
                    end else if (bus.in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_work_nxt  = '0;
                        w_mode_nxt  = 1'b0;
                        w_zero_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_work_nxt = bus.in_vec;
            w_mode_nxt = bus.in_mode;
            w_zero_nxt = (bus.in_vec == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_mode <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            r_work <= w_work_nxt;
            r_mode <= w_mode_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_idx   = w_out_idx;
    assign bus.out_last  = w_out_last;
    assign bus.out_zero  = w_out_zero;
endmodule

// File: tb/tb_priority_bit_scanner.sv
// Directed bench for priority_bit_scanner: four instances cover MSB/LSB priority,
// a narrow 5-bit variant and a 64-bit variant checked against a small ordering model.
module tb_priority_bit_scanner;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        v_valid [4];
    logic [63:0] v_vec   [4];
    logic        v_mode  [4];
    logic        v_ordy  [4];
    logic        o_valid [4];
    logic        o_inrdy [4];
    logic        o_last  [4];
    logic        o_zero  [4];
    logic [7:0]  o_idx   [4];

    logic [7:0] got_idx  [$];
    logic       got_last [$];
    logic       got_zero [$];

    priority_bit_scanner_if #(.WIDTH(16), .OUT_W(8)) if0 ();
    priority_bit_scanner_if #(.WIDTH(16), .OUT_W(8)) if1 ();
    priority_bit_scanner_if #(.WIDTH(5),  .OUT_W(3)) if2 ();
    priority_bit_scanner_if #(.WIDTH(64), .OUT_W(8)) if3 ();

    assign if0.in_valid = v_valid[0];  assign if0.in_vec = v_vec[0][15:0];
    assign if0.in_mode  = v_mode[0];   assign if0.out_ready = v_ordy[0];
    assign if1.in_valid = v_valid[1];  assign if1.in_vec = v_vec[1][15:0];
    assign if1.in_mode  = v_mode[1];   assign if1.out_ready = v_ordy[1];
    assign if2.in_valid = v_valid[2];  assign if2.in_vec = v_vec[2][4:0];
    assign if2.in_mode  = v_mode[2];   assign if2.out_ready = v_ordy[2];
    assign if3.in_valid = v_valid[3];  assign if3.in_vec = v_vec[3];
    assign if3.in_mode  = v_mode[3];   assign if3.out_ready = v_ordy[3];

    assign o_valid[0] = if0.out_valid; assign o_inrdy[0] = if0.in_ready;
    assign o_last[0]  = if0.out_last;  assign o_zero[0]  = if0.out_zero;
    assign o_idx[0]   = if0.out_idx;
    assign o_valid[1] = if1.out_valid; assign o_inrdy[1] = if1.in_ready;
    assign o_last[1]  = if1.out_last;  assign o_zero[1]  = if1.out_zero;
    assign o_idx[1]   = if1.out_idx;
    assign o_valid[2] = if2.out_valid; assign o_inrdy[2] = if2.in_ready;
    assign o_last[2]  = if2.out_last;  assign o_zero[2]  = if2.out_zero;
    assign o_idx[2]   = {5'b0, if2.out_idx};
    assign o_valid[3] = if3.out_valid; assign o_inrdy[3] = if3.in_ready;
    assign o_last[3]  = if3.out_last;  assign o_zero[3]  = if3.out_zero;
    assign o_idx[3]   = if3.out_idx;

    priority_bit_scanner #(.WIDTH(16), .OUT_W(8), .ZERO_CODE(64'hF0), .MSB_FIRST(1'b1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    priority_bit_scanner #(.WIDTH(16), .OUT_W(8), .ZERO_CODE(64'hF0), .MSB_FIRST(1'b0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    priority_bit_scanner #(.WIDTH(5), .OUT_W(3), .ZERO_CODE(64'h7), .MSB_FIRST(1'b1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    priority_bit_scanner #(.WIDTH(64), .OUT_W(8), .ZERO_CODE(64'hF0), .MSB_FIRST(1'b1))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance with in_valid dropped.
    task automatic offer(input int d, input logic [63:0] vec, input logic mode);
        logic rdy;
        logic acc;
        acc = 1'b0;
        v_vec[d]   = vec;
        v_mode[d]  = mode;
        v_valid[d] = 1'b1;
        for (int t = 0; t < 50; t++) begin
            #1 rdy = o_inrdy[d];
            @(posedge clk);
            if (rdy) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        v_valid[d] = 1'b0;
        chk($sformatf("offer_accepted_d%0d", d), {63'b0, acc}, 64'd1);
    endtask

    // Called at a falling edge with out_ready high; records beats until out_last is taken.
    task automatic collect(input int d, input int budget, output int cycles);
        logic done;
        done = 1'b0;
        cycles = 0;
        got_idx.delete();
        got_last.delete();
        got_zero.delete();
        while (!done && cycles < budget) begin
            if (o_valid[d] && v_ordy[d]) begin
                got_idx.push_back(o_idx[d]);
                got_last.push_back(o_last[d]);
                got_zero.push_back(o_zero[d]);
                if (o_last[d]) done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        chk($sformatf("collect_done_d%0d", d), {63'b0, done}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nlast;
        logic [63:0] rv;
        logic [7:0]  exp_q [$];

        for (int d = 0; d < 4; d++) begin
            v_valid[d] = 1'b0;
            v_vec[d]   = '0;
            v_mode[d]  = 1'b0;
            v_ordy[d]  = 1'b1;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  {63'b0, o_inrdy[0]}, 64'd1);
        chk("rst_out_valid", {63'b0, o_valid[0]}, 64'd0);
        chk("rst_out_idx",   {56'b0, o_idx[0]},   64'd0);
        chk("rst_out_last",  {63'b0, o_last[0]},  64'd0);
        chk("rst_out_zero",  {63'b0, o_zero[0]},  64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // all-zero vector, single mode
        offer(0, 64'h0, 1'b0);
        chk("zero_latency_valid", {63'b0, o_valid[0]}, 64'd1);
        collect(0, 10, cyc);
        chk("zero_beats", 64'(got_idx.size()), 64'd1);
        chk("zero_idx",   {56'b0, got_idx[0]}, 64'hF0);
        chk("zero_flag",  {63'b0, got_zero[0]}, 64'd1);
        chk("zero_last",  {63'b0, got_last[0]}, 64'd1);
        chk("zero_back_idle", {63'b0, o_valid[0]}, 64'd0);

        // single mode priority, both orders
        offer(0, 64'h0A40, 1'b0);
        collect(0, 10, cyc);
        chk("single_msb_beats", 64'(got_idx.size()), 64'd1);
        chk("single_msb_idx",   {56'b0, got_idx[0]}, 64'd11);
        chk("single_msb_last",  {63'b0, got_last[0]}, 64'd1);
        offer(1, 64'h0A40, 1'b0);
        collect(1, 10, cyc);
        chk("single_lsb_idx",   {56'b0, got_idx[0]}, 64'd6);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                offer(d, 64'd1 << i, 1'b0);
                chk($sformatf("onehot_d%0d_b%0d", d, i), {56'b0, o_idx[d]}, 64'(i));
                collect(d, 10, cyc);
            end
        end

        // enumerate with out_ready high: one beat per cycle
        offer(0, 64'h8421, 1'b1);
        collect(0, 20, cyc);
        chk("enum_cycles", 64'(cyc), 64'd4);
        chk("enum_beats",  64'(got_idx.size()), 64'd4);
        chk("enum_i0", {56'b0, got_idx[0]}, 64'd15);
        chk("enum_i1", {56'b0, got_idx[1]}, 64'd10);
        chk("enum_i2", {56'b0, got_idx[2]}, 64'd5);
        chk("enum_i3", {56'b0, got_idx[3]}, 64'd0);
        chk("enum_lastmask", {60'b0, got_last[0], got_last[1], got_last[2], got_last[3]}, 64'b0001);
        chk("enum_idle_valid", {63'b0, o_valid[0]}, 64'd0);
        chk("enum_idle_ready", {63'b0, o_inrdy[0]}, 64'd1);
        offer(1, 64'h8421, 1'b1);
        collect(1, 20, cyc);
        chk("enum_lsb_i0", {56'b0, got_idx[0]}, 64'd0);
        chk("enum_lsb_i1", {56'b0, got_idx[1]}, 64'd5);
        chk("enum_lsb_i3", {56'b0, got_idx[3]}, 64'd15);

        // backpressure holds the beat
        v_ordy[0] = 1'b0;
        offer(0, 64'h0011, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_valid_%0d", k), {63'b0, o_valid[0]}, 64'd1);
            chk($sformatf("bp_idx_%0d", k),   {56'b0, o_idx[0]},   64'd4);
            chk($sformatf("bp_last_%0d", k),  {63'b0, o_last[0]},  64'd0);
            @(negedge clk);
        end
        v_ordy[0] = 1'b1;
        collect(0, 10, cyc);
        chk("bp_beats", 64'(got_idx.size()), 64'd2);
        chk("bp_i0", {56'b0, got_idx[0]}, 64'd4);
        chk("bp_i1", {56'b0, got_idx[1]}, 64'd0);

        // back-to-back single-mode stream
        v_mode[0]  = 1'b0;
        v_vec[0]   = 64'h0001;
        v_valid[0] = 1'b1;
        @(negedge clk);
        chk("b2b_v0", {63'b0, o_valid[0]}, 64'd1);
        chk("b2b_i0", {56'b0, o_idx[0]},   64'd0);
        chk("b2b_r0", {63'b0, o_inrdy[0]}, 64'd1);
        v_vec[0] = 64'h8000;
        @(negedge clk);
        chk("b2b_v1", {63'b0, o_valid[0]}, 64'd1);
        chk("b2b_i1", {56'b0, o_idx[0]},   64'd15);
        v_vec[0] = 64'hFFFF;
        @(negedge clk);
        chk("b2b_v2", {63'b0, o_valid[0]}, 64'd1);
        chk("b2b_i2", {56'b0, o_idx[0]},   64'd15);
        chk("b2b_l2", {63'b0, o_last[0]},  64'd1);
        v_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {63'b0, o_valid[0]}, 64'd0);

        // reset in the middle of an enumeration
        offer(0, 64'hFFFF, 1'b1);
        chk("rst_mid_b0", {56'b0, o_idx[0]}, 64'd15);
        @(negedge clk);
        chk("rst_mid_b1", {56'b0, o_idx[0]}, 64'd14);
        @(negedge clk);
        chk("rst_mid_b2", {56'b0, o_idx[0]}, 64'd13);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'b0, o_valid[0]}, 64'd0);
        chk("rst_mid_ready", {63'b0, o_inrdy[0]}, 64'd1);
        chk("rst_mid_idx",   {56'b0, o_idx[0]},   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {63'b0, o_valid[0]}, 64'd0);
        offer(0, 64'h0002, 1'b0);
        collect(0, 10, cyc);
        chk("post_rst_beats", 64'(got_idx.size()), 64'd1);
        chk("post_rst_idx",   {56'b0, got_idx[0]}, 64'd1);

        // narrow variant
        offer(2, 64'b10100, 1'b1);
        collect(2, 10, cyc);
        chk("w5_beats", 64'(got_idx.size()), 64'd2);
        chk("w5_i0", {56'b0, got_idx[0]}, 64'd4);
        chk("w5_i1", {56'b0, got_idx[1]}, 64'd2);
        offer(2, 64'b00000, 1'b1);
        collect(2, 10, cyc);
        chk("w5_zero_beats", 64'(got_idx.size()), 64'd1);
        chk("w5_zero_idx",   {56'b0, got_idx[0]}, 64'd7);
        chk("w5_zero_flag",  {63'b0, got_zero[0]}, 64'd1);

        // wide variant: fixed corner plus random vectors against an ordering model
        for (int r = 0; r < 6; r++) begin
            rv = (r == 0) ? 64'h8000_0000_0000_0001 : {$urandom(), $urandom()};
            exp_q.delete();
            for (int i = 63; i >= 0; i--) begin
                if (rv[i]) exp_q.push_back(8'(i));
            end
            if (exp_q.size() == 0) exp_q.push_back(8'hF0);
            offer(3, rv, 1'b1);
            collect(3, 80, cyc);
            chk($sformatf("w64_r%0d_beats", r), 64'(got_idx.size()), 64'(exp_q.size()));
            nlast = 0;
            for (int k = 0; k < got_idx.size() && k < exp_q.size(); k++) begin
                chk($sformatf("w64_r%0d_k%0d", r, k), {56'b0, got_idx[k]}, {56'b0, exp_q[k]});
                if (got_last[k]) nlast++;
            end
            chk($sformatf("w64_r%0d_lastcount", r), 64'(nlast), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
